// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad capture path: key codes, FSM states and
// the digit classifier used by the operand capture logic.
package keypad_pkg;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_EQ  = 4'hB;
  localparam logic [3:0] KEY_CLR = 4'hC;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    SHOW    = 2'd2
  } state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/module_bcd_accum.sv
// Decimal entry accumulator: holds the operand being typed and its digit count,
// appending a digit as value*10+digit until the digit limit is reached.
module module_bcd_accum
  import keypad_pkg::*;
#(
  parameter int N_DIGITS = 3,
  parameter int WIDTH    = 12
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             clear,
  input  logic             load,
  input  logic [3:0]       digit,
  output logic [WIDTH-1:0] entry_value,
  output logic [1:0]       entry_digits
);

  localparam logic [1:0] MAX_DIGITS = 2'(N_DIGITS);

  logic [WIDTH-1:0] value_r;
  logic [WIDTH-1:0] value_next_s;
  logic [WIDTH-1:0] base_value_s;
  logic [WIDTH-1:0] scaled_s;
  logic [1:0]       digits_r;
  logic [1:0]       digits_next_s;
  logic [1:0]       base_digits_s;

  // Next-value datapath; clear together with load starts a fresh entry with this digit
  always_comb begin
    base_value_s  = {WIDTH{1'b0}};
    base_digits_s = 2'd0;
    if (clear) begin
      base_value_s  = {WIDTH{1'b0}};
      base_digits_s = 2'd0;
    end else begin
      base_value_s  = value_r;
      base_digits_s = digits_r;
    end
    // Only evaluated below the digit limit, so the product never exceeds WIDTH bits
    scaled_s = (base_value_s << 3) + (base_value_s << 1) + {{(WIDTH-4){1'b0}}, digit};
    value_next_s  = base_value_s;
    digits_next_s = base_digits_s;
    if (load && (base_digits_s < MAX_DIGITS)) begin
      value_next_s  = scaled_s;
      digits_next_s = base_digits_s + 2'd1;
    end else begin
      value_next_s  = base_value_s;
      digits_next_s = base_digits_s;
    end
  end

  // Entry value and digit count registers
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      value_r  <= {WIDTH{1'b0}};
      digits_r <= 2'd0;
    end else begin
      value_r  <= value_next_s;
      digits_r <= digits_next_s;
    end
  end

  assign entry_value  = value_r;
  assign entry_digits = digits_r;

endmodule

// File: rtl/module_key_capture.sv
// Keypad operand capture: builds operands A and B from debounced key strobes
// and presents their registered sum with a one-cycle valid pulse on EQUALS.
module module_key_capture
  import keypad_pkg::*;
#(
  parameter int N_DIGITS = 3,
  parameter int WIDTH    = 12
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic [3:0]       key_code,
  input  logic             key_valid,
  output logic [WIDTH-1:0] entry_value,
  output logic [1:0]       entry_digits,
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic [WIDTH:0]   result,
  output logic             result_valid,
  output logic             busy_b
);

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] operand_a_r;
  logic [WIDTH-1:0] operand_a_next_s;
  logic [WIDTH-1:0] operand_b_r;
  logic [WIDTH-1:0] operand_b_next_s;
  logic [WIDTH:0]   result_r;
  logic [WIDTH:0]   result_next_s;
  logic             result_valid_r;
  logic             result_valid_next_s;
  logic             busy_b_r;
  logic             busy_b_next_s;
  logic             acc_clear_s;
  logic             acc_load_s;
  logic [WIDTH-1:0] entry_value_s;
  logic [1:0]       entry_digits_s;

  module_bcd_accum #(
    .N_DIGITS (N_DIGITS),
    .WIDTH    (WIDTH)
  ) u_accum (
    .clk          (clk),
    .n_reset      (n_reset),
    .clear        (acc_clear_s),
    .load         (acc_load_s),
    .digit        (key_code),
    .entry_value  (entry_value_s),
    .entry_digits (entry_digits_s)
  );

  // Next-state and next-output decode for one accepted key strobe
  always_comb begin
    state_next_s        = state_r;
    operand_a_next_s    = operand_a_r;
    operand_b_next_s    = operand_b_r;
    result_next_s       = result_r;
    result_valid_next_s = 1'b0;
    busy_b_next_s       = busy_b_r;
    acc_clear_s         = 1'b0;
    acc_load_s          = 1'b0;
    if (key_valid) begin
      if (key_code == KEY_CLR) begin
        state_next_s     = ENTER_A;
        operand_a_next_s = {WIDTH{1'b0}};
        operand_b_next_s = {WIDTH{1'b0}};
        result_next_s    = {(WIDTH+1){1'b0}};
        busy_b_next_s    = 1'b0;
        acc_clear_s      = 1'b1;
      end else begin
        case (state_r)
          ENTER_A: begin
            if (is_digit(key_code)) begin
              acc_load_s = 1'b1;
            end else if (key_code == KEY_ADD) begin
              operand_a_next_s = entry_value_s;
              acc_clear_s      = 1'b1;
              busy_b_next_s    = 1'b1;
              state_next_s     = ENTER_B;
            end else begin
              state_next_s = ENTER_A;
            end
          end
          ENTER_B: begin
            if (is_digit(key_code)) begin
              acc_load_s = 1'b1;
            end else if (key_code == KEY_EQ) begin
              operand_b_next_s    = entry_value_s;
              result_next_s       = {1'b0, operand_a_r} + {1'b0, entry_value_s};
              result_valid_next_s = 1'b1;
              busy_b_next_s       = 1'b0;
              state_next_s        = SHOW;
            end else begin
              state_next_s = ENTER_B;
            end
          end
          SHOW: begin
            if (is_digit(key_code)) begin
              acc_clear_s  = 1'b1;
              acc_load_s   = 1'b1;
              state_next_s = ENTER_A;
            end else if (key_code == KEY_ADD) begin
              // Chain: the previous sum becomes the new first operand
              operand_a_next_s = result_r[WIDTH-1:0];
              acc_clear_s      = 1'b1;
              busy_b_next_s    = 1'b1;
              state_next_s     = ENTER_B;
            end else begin
              state_next_s = SHOW;
            end
          end
          default: begin
            state_next_s = ENTER_A;
          end
        endcase
      end
    end else begin
      state_next_s = state_r;
    end
  end

  // State and committed-output registers
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_r        <= ENTER_A;
      operand_a_r    <= {WIDTH{1'b0}};
      operand_b_r    <= {WIDTH{1'b0}};
      result_r       <= {(WIDTH+1){1'b0}};
      result_valid_r <= 1'b0;
      busy_b_r       <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      operand_a_r    <= operand_a_next_s;
      operand_b_r    <= operand_b_next_s;
      result_r       <= result_next_s;
      result_valid_r <= result_valid_next_s;
      busy_b_r       <= busy_b_next_s;
    end
  end

  assign entry_value  = entry_value_s;
  assign entry_digits = entry_digits_s;
  assign operand_a    = operand_a_r;
  assign operand_b    = operand_b_r;
  assign result       = result_r;
  assign result_valid = result_valid_r;
  assign busy_b       = busy_b_r;

endmodule

// File: tb/tb_module_key_capture.sv
// Self-checking bench: a behavioural keypad model tracks every output per key,
// and committed sums are queued on EQUALS and compared when result_valid fires.
module tb_module_key_capture;
  import keypad_pkg::*;

  localparam int N_DIGITS = 3;
  localparam int WIDTH    = 12;

  logic             clk = 1'b0;
  logic             n_reset = 1'b0;
  logic [3:0]       key_code = 4'd0;
  logic             key_valid = 1'b0;
  logic [WIDTH-1:0] entry_value;
  logic [1:0]       entry_digits;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH:0]   result;
  logic             result_valid;
  logic             busy_b;

  module_key_capture #(.N_DIGITS(N_DIGITS), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .entry_value  (entry_value),
    .entry_digits (entry_digits),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .result       (result),
    .result_valid (result_valid),
    .busy_b       (busy_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int res;
    int cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Reference model of the capture logic
  int m_entry, m_digits, m_a, m_b, m_res, m_busy, m_st, m_rv;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_state(input string where);
    check_val({where, ":entry_value"},  32'(entry_value),  32'(m_entry));
    check_val({where, ":entry_digits"}, 32'(entry_digits), 32'(m_digits));
    check_val({where, ":operand_a"},    32'(operand_a),    32'(m_a));
    check_val({where, ":operand_b"},    32'(operand_b),    32'(m_b));
    check_val({where, ":result"},       32'(result),       32'(m_res));
    check_val({where, ":busy_b"},       32'(busy_b),       32'(m_busy));
    check_val({where, ":result_valid"}, 32'(result_valid), 32'(m_rv));
  endtask

  task automatic model_reset();
    m_entry = 0; m_digits = 0; m_a = 0; m_b = 0; m_res = 0;
    m_busy = 0; m_st = 0; m_rv = 0;
  endtask

  task automatic model_append(input int code);
    if (m_digits < N_DIGITS) begin
      m_entry  = m_entry * 10 + code;
      m_digits = m_digits + 1;
    end
  endtask

  task automatic model_key(input int code);
    exp_t e;
    m_rv = 0;
    if (code == 12) begin
      model_reset();
    end else begin
      case (m_st)
        0: begin
          if (code <= 9) model_append(code);
          else if (code == 10) begin
            m_a = m_entry; m_entry = 0; m_digits = 0; m_busy = 1; m_st = 1;
          end
        end
        1: begin
          if (code <= 9) model_append(code);
          else if (code == 11) begin
            m_b = m_entry; m_res = m_a + m_entry; m_rv = 1; m_busy = 0; m_st = 2;
            e.a = m_a; e.b = m_b; e.res = m_res; e.cyc = cyc + 1;
            sb_q.push_back(e);
          end
        end
        default: begin
          if (code <= 9) begin
            m_entry = code; m_digits = 1; m_st = 0;
          end else if (code == 10) begin
            m_a = m_res % 4096; m_entry = 0; m_digits = 0; m_busy = 1; m_st = 1;
          end
        end
      endcase
    end
  endtask

  // One strobe per call; consecutive calls give back-to-back strobes
  task automatic press(input logic [3:0] code);
    key_code  = code;
    key_valid = 1'b1;
    model_key(int'(code));
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key_code  = 4'($urandom_range(15));
    check_state($sformatf("key_%h", code));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      key_code = 4'($urandom_range(15));
      @(posedge clk);
      #1;
      m_rv = 0;
      check_state("idle");
    end
  endtask

  // Scoreboard: each result_valid pulse must match the oldest queued sum and cycle
  always @(negedge clk) begin
    if (n_reset && result_valid) begin
      if (sb_q.size() == 0) begin
        check_val("rv_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_val("sb_result",    32'(result),    32'(e.res));
        check_val("sb_operand_a", 32'(operand_a), 32'(e.a));
        check_val("sb_operand_b", 32'(operand_b), 32'(e.b));
        check_val("sb_latency",   32'(cyc),       32'(e.cyc));
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    n_reset = 1'b1;
    idle(1);

    // Reset mid-entry
    press(4'h1); press(4'h2);
    n_reset = 1'b0;
    #1;
    model_reset();
    check_state("rst_async");
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    check_state("rst_release");
    idle(1);

    // Basic sum
    press(4'h1); press(4'h2); press(4'h3); press(KEY_ADD);
    press(4'h4); press(4'h5); press(KEY_EQ);
    idle(2);

    // Digit limit and full-width sum
    press(KEY_CLR);
    press(4'h9); press(4'h9); press(4'h9); press(4'h9);
    press(KEY_ADD); press(4'h9); press(4'h9); press(4'h9); press(4'h9);
    press(KEY_EQ);
    idle(1);

    // Empty operands, ignored keys
    press(KEY_CLR);
    press(KEY_EQ); press(4'hE); press(4'hD); press(4'hF);
    press(KEY_ADD); press(KEY_ADD); press(KEY_EQ);
    press(KEY_EQ);
    idle(1);

    // Chaining then fresh start from SHOW
    press(KEY_CLR);
    press(4'h5); press(KEY_ADD); press(4'h7); press(KEY_EQ);
    press(KEY_ADD); press(4'h3); press(KEY_EQ);
    idle(1);
    press(4'h8);
    idle(1);

    // Clear during operand B, back-to-back digits
    press(4'h4); press(KEY_ADD); press(4'h6);
    press(KEY_CLR);
    press(4'h1); press(4'h2);
    idle(2);

    check_val("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/module_key_capture.md
Name: module_key_capture

Overview:
- Downstream consumer of the keypad scanner stage. Takes one debounced 4-bit key code per press and assembles two decimal operands of up to N_DIGITS digits each.
- On the equals key it commits both operands and presents their sum for one-cycle pickup by the display/arith stage.
- Also exposes the operand currently being typed, for live display.

Parameters:
- N_DIGITS, 3, maximum decimal digits per operand.
- WIDTH, 12, binary width of each operand; must hold 10^N_DIGITS - 1.

Ports:
- clk  input  1  system clock (27 MHz board clock).
- n_reset  input  1  asynchronous active-low reset.
- key_code  input  4  key code from the scanner stage; sampled only when key_valid=1.
- key_valid  input  1  one-cycle strobe, one per physical press.
- entry_value  output  WIDTH  binary value of the operand currently being typed.
- entry_digits  output  2  digits typed into the current operand (0..N_DIGITS).
- operand_a  output  WIDTH  committed first operand.
- operand_b  output  WIDTH  committed second operand.
- result  output  WIDTH+1  operand_a + operand_b, registered.
- result_valid  output  1  one-cycle pulse when result updates.
- busy_b  output  1  high while typing operand B.

Behaviour:
- Key map:
  - 0x0-0x9: digit.
  - 0xA: ADD (commit A, start B).
  - 0xB: EQUALS.
  - 0xC: CLEAR.
  - 0xD-0xF: ignored, no state change.
- Reset (async assert, sync release): state=ENTER_A. All outputs 0 (entry_value, entry_digits, operand_a, operand_b, result, result_valid, busy_b).
- States: ENTER_A, ENTER_B, SHOW. Encoding lives in the shared package.
- Digit key in ENTER_A/ENTER_B:
  - If entry_digits < N_DIGITS: entry_value <= entry_value*10 + code, entry_digits += 1.
  - Otherwise ignore; no wrap, no overflow.
  - Visible the cycle after the strobe.
- ENTER_A + ADD:
  - operand_a <= entry_value; entry_value <= 0; entry_digits <= 0; busy_b <= 1; go to ENTER_B.
  - ADD with 0 digits commits A=0.
- ENTER_A + EQUALS: ignored.
- ENTER_B + EQUALS:
  - operand_b <= entry_value; result <= operand_a + entry_value, computed at full WIDTH+1.
  - result_valid=1 for exactly the next cycle; busy_b <= 0; go to SHOW.
  - Latency: 1 clk from strobe to result_valid.
- ENTER_B + ADD: ignored.
- SHOW:
  - Digit key behaves as a fresh start: entry cleared, then the digit is loaded as the first digit; go to ENTER_A. operand_a/b/result are held until the next commit.
  - ADD in SHOW: operand_a <= result[WIDTH-1:0] (chaining), entry cleared, go to ENTER_B.
  - EQUALS in SHOW: ignored.
- CLEAR in any state: entry_value, entry_digits, operand_a, operand_b, result, busy_b <= 0; go to ENTER_A; result_valid stays 0.
- key_valid=0: hold everything. key_code changes without a strobe have no effect.
- Back-to-back strobes on consecutive cycles are each processed, in order.
- result_valid never stays high for more than 1 cycle.
- Reset asserted mid-entry: immediate return to reset values; no result_valid pulse.

Decomposition:
- Shared package (keypad_pkg):
  - key code constants KEY_ADD=4'hA, KEY_EQ=4'hB, KEY_CLR=4'hC.
  - state enum typedef.
  - function is_digit(code).
- Sub-module: module_bcd_accum (entry_value/entry_digits register plus the *10+digit datapath, with load/clear controls). The FSM stays in the top.

Test Plan:
- Reset mid-entry: digits 1,2 then n_reset low for 1 cycle -> all outputs 0, state ENTER_A.
- Keys 1,2,3,ADD,4,5,EQ -> operand_a=123, operand_b=45, result=168, result_valid high exactly 1 cycle after the EQ strobe.
- Keys 9,9,9,9 (4th digit) -> entry_value=999, entry_digits=3. Then ADD,9,9,9,EQ -> result=1998, with no truncation in the WIDTH+1 result.
- Keys ADD,EQ with no digits -> operand_a=0, operand_b=0, result=0, result_valid pulse. Keys EQ in ENTER_A and 0xE -> no change, no pulse.
- Chaining: 5,ADD,7,EQ (result=12), then ADD,3,EQ -> operand_a=12, result=15. Then a digit 8 -> ENTER_A, entry_value=8, result still 15.
- CLEAR during ENTER_B after 4,ADD,6 -> all values 0, busy_b=0. Strobes on consecutive cycles: 1,2 -> entry_value=12.
